mem_stage_ctrl: RTL and testbench

Memory-stage access controller for the pipelined LC-3b datapath. It sits between the EX/MEM pipeline latch and the writeback latch. It sequences data-cache accesses for LDR/STR/LDB/STB/LDI/STI, including the two-access indirect forms and byte lane handling. It produces the MDR value consumed by the writeback latch and holds the pipeline with a stall while an access is outstanding.

---
 rtl/mem_stage_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// LC-3b memory-stage access controller: sequences direct, byte and indirect
// data-cache accesses and stalls the pipeline while an access is outstanding.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        indirect,
  input  logic        byte_op,
  input  logic [15:0] addr_in,
  input  logic [15:0] store_data,
  input  logic        advance,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_en,
  output logic [15:0] mdr_out,
  output logic        stall_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic [15:0] word_align(input logic [15:0] a);
    word_align = {a[15:1], 1'b0};
  endfunction

  function automatic logic [1:0] store_lanes(input logic is_byte, input logic a0);
    if (is_byte) begin
      store_lanes = a0 ? 2'b10 : 2'b01;
    end else begin
      store_lanes = 2'b11;
    end
  endfunction

  function automatic logic [15:0] store_word(input logic is_byte, input logic [15:0] d);
    store_word = is_byte ? {d[7:0], d[7:0]} : d;
  endfunction

  function automatic logic [15:0] load_format(input logic is_byte, input logic a0,
                                              input logic [15:0] d);
    if (!is_byte) begin
      load_format = d;
    end else if (a0) begin
      load_format = {{8{d[15]}}, d[15:8]};
    end else begin
      load_format = {{8{d[7]}}, d[7:0]};
    end
  endfunction

  state_t      state_r, state_n;
  logic        read_r, write_r, read_n, write_n;
  logic [15:0] addr_r, wdata_r, mdr_r, addr_n, wdata_n, mdr_n;
  logic [1:0]  be_r, be_n;
  logic        stall_s;
  logic        mem_instr_s, first_read_s;

  logic        rd_r, ind_r, byte_r, addr0_r;
  logic [15:0] store_data_r;

  assign mem_instr_s  = valid_in & (mem_read | mem_write);
  assign first_read_s = mem_read | indirect;

  // Next-state and next-request decode; request outputs are registered below.
  always_comb begin
    state_n = state_r;
    read_n  = read_r;
    write_n = write_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    be_n    = be_r;
    mdr_n   = mdr_r;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_instr_s) begin
          stall_s = 1'b1;
          state_n = ACC1;
          read_n  = first_read_s;
          write_n = mem_write & ~first_read_s;
          addr_n  = word_align(addr_in);
          if (mem_write & ~first_read_s) begin
            wdata_n = store_word(byte_op, store_data);
            be_n    = store_lanes(byte_op, addr_in[0]);
          end else begin
            wdata_n = 16'h0000;
            be_n    = 2'b00;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      ACC1: begin
        stall_s = 1'b1;
        if (!dmem_resp) begin
          state_n = ACC1;
        end else if (ind_r) begin
          // The returned word is the pointer for the second access.
          state_n = ACC2;
          addr_n  = word_align(dmem_rdata);
          if (rd_r) begin
            read_n  = 1'b1;
            write_n = 1'b0;
            wdata_n = 16'h0000;
            be_n    = 2'b00;
          end else begin
            read_n  = 1'b0;
            write_n = 1'b1;
            wdata_n = store_data_r;
            be_n    = 2'b11;
          end
        end else begin
          state_n = DONE;
          read_n  = 1'b0;
          write_n = 1'b0;
          be_n    = 2'b00;
          if (rd_r) begin
            mdr_n = load_format(byte_r, addr0_r, dmem_rdata);
          end else begin
            mdr_n = mdr_r;
          end
        end
      end
      ACC2: begin
        stall_s = 1'b1;
        if (dmem_resp) begin
          state_n = DONE;
          read_n  = 1'b0;
          write_n = 1'b0;
          be_n    = 2'b00;
          if (rd_r) begin
            mdr_n = dmem_rdata;
          end else begin
            mdr_n = mdr_r;
          end
        end else begin
          state_n = ACC2;
        end
      end
      DONE: begin
        if (advance) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
        read_n  = 1'b0;
        write_n = 1'b0;
        be_n    = 2'b00;
      end
    endcase
  end

  // State, request and load-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      read_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      be_r    <= 2'b00;
      mdr_r   <= 16'h0000;
    end else begin
      state_r <= state_n;
      read_r  <= read_n;
      write_r <= write_n;
      addr_r  <= addr_n;
      wdata_r <= wdata_n;
      be_r    <= be_n;
      mdr_r   <= mdr_n;
    end
  end

  // Instruction fields are captured only when an instruction is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r         <= 1'b0;
      ind_r        <= 1'b0;
      byte_r       <= 1'b0;
      addr0_r      <= 1'b0;
      store_data_r <= 16'h0000;
    end else if ((state_r == IDLE) && mem_instr_s) begin
      rd_r         <= mem_read;
      ind_r        <= indirect;
      byte_r       <= byte_op;
      addr0_r      <= addr_in[0];
      store_data_r <= store_data;
    end else begin
      rd_r         <= rd_r;
      ind_r        <= ind_r;
      byte_r       <= byte_r;
      addr0_r      <= addr0_r;
      store_data_r <= store_data_r;
    end
  end

  assign dmem_read    = read_r;
  assign dmem_write   = write_r;
  assign dmem_addr    = addr_r;
  assign dmem_wdata   = wdata_r;
  assign dmem_byte_en = be_r;
  assign mdr_out      = mdr_r;
  assign stall_mem    = stall_s;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; the bench plays the data
// cache and the pipeline, and every expected value is hand-computed.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        indirect = 1'b0, byte_op = 1'b0, advance = 1'b0, dmem_resp = 1'b0;
  logic [15:0] addr_in = 16'h0000, store_data = 16'h0000, dmem_rdata = 16'h0000;
  logic        dmem_read, dmem_write, stall_mem;
  logic [15:0] dmem_addr, dmem_wdata, mdr_out;
  logic [1:0]  dmem_byte_en;

  int n_checks = 0;
  int n_fails  = 0;

  int          cyc, stl, req, dreq;
  logic [15:0] a1, a2, wd1, wd2, mdr_d;
  logic [1:0]  be1, be2, k1, k2;

  mem_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .indirect(indirect), .byte_op(byte_op),
    .addr_in(addr_in), .store_data(store_data), .advance(advance),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_byte_en(dmem_byte_en), .mdr_out(mdr_out), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Presents one instruction, answers each request after w1/w2 wait cycles,
  // holds advance low for adv_hold DONE cycles and records what it observed.
  task automatic run_access(input logic rd, wr, ind, bop, input logic [15:0] addr, sd,
                            input logic [15:0] r1, r2, input int w1, w2, adv_hold);
    int resp_cnt, wseen, hold;
    logic done_seen;
    @(negedge clk);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; indirect = ind; byte_op = bop;
    addr_in = addr; store_data = sd; advance = 1'b0; dmem_resp = 1'b0;
    cyc = 0; stl = 0; req = 0; dreq = 0; resp_cnt = 0; wseen = 0; hold = 0;
    done_seen = 1'b0;
    a1 = 'x; a2 = 'x; wd1 = 'x; wd2 = 'x; mdr_d = 'x; be1 = 'x; be2 = 'x; k1 = 'x; k2 = 'x;
    for (int k = 0; k < 60; k++) begin
      #1;
      cyc++;
      if (stall_mem) stl++;
      if (k >= 1) begin
        addr_in = ~addr; store_data = ~sd; byte_op = ~bop;
      end
      dmem_resp = 1'b0;
      if (k > 0 && !stall_mem) begin
        if (dmem_read || dmem_write) dreq++;
        if (!done_seen) begin
          done_seen = 1'b1;
          mdr_d = mdr_out;
        end
        if (hold >= adv_hold) begin
          advance = 1'b1;
          break;
        end
        hold++;
      end else if (dmem_read || dmem_write) begin
        req++;
        if (resp_cnt == 0 && wseen == 0) begin
          a1 = dmem_addr; wd1 = dmem_wdata; be1 = dmem_byte_en; k1 = {dmem_read, dmem_write};
        end
        if (resp_cnt == 1 && wseen == 0) begin
          a2 = dmem_addr; wd2 = dmem_wdata; be2 = dmem_byte_en; k2 = {dmem_read, dmem_write};
        end
        if (wseen < ((resp_cnt == 0) ? w1 : w2)) begin
          wseen++;
        end else begin
          dmem_resp = 1'b1;
          dmem_rdata = (resp_cnt == 0) ? r1 : r2;
          resp_cnt++;
          wseen = 0;
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; indirect = 1'b0; byte_op = 1'b0;
    advance = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({dmem_read, dmem_write, dmem_byte_en, stall_mem} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b be=%b stall=%b required all 0",
               dmem_read, dmem_write, dmem_byte_en, stall_mem);
    end
    n_checks++;
    if ({dmem_addr, dmem_wdata, mdr_out} !== 48'h0) begin
      n_fails++;
      $display("FAIL reset_data: got addr=%h wdata=%h mdr=%h required 0", dmem_addr, dmem_wdata, mdr_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ldr;
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h3002, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0);
    n_checks++;
    if ({a1, k1, 16'(req), 16'(stl), 16'(cyc)} !== {16'h3002, 2'b10, 16'd1, 16'd2, 16'd3}) begin
      n_fails++;
      $display("FAIL ldr_seq: got addr=%h kind=%b req=%0d stall=%0d cyc=%0d required 3002 10 1 2 3",
               a1, k1, req, stl, cyc);
    end
    n_checks++;
    if (mdr_d !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL ldr_mdr: got %h required BEEF", mdr_d);
    end
  endtask

  task automatic test_stb;
    run_access(1'b0, 1'b1, 1'b0, 1'b1, 16'h4001, 16'h12A5, 16'h0000, 16'h0000, 0, 0, 0);
    n_checks++;
    if ({k1, a1, wd1, be1} !== {2'b01, 16'h4000, 16'hA5A5, 2'b10}) begin
      n_fails++;
      $display("FAIL stb_odd: got kind=%b addr=%h wdata=%h be=%b required 01 4000 A5A5 10", k1, a1, wd1, be1);
    end
    run_access(1'b0, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h12A5, 16'h0000, 16'h0000, 1, 0, 0);
    n_checks++;
    if ({k1, a1, wd1, be1, 16'(stl)} !== {2'b01, 16'h4000, 16'hA5A5, 2'b01, 16'd3}) begin
      n_fails++;
      $display("FAIL stb_even: got kind=%b addr=%h wdata=%h be=%b stall=%0d required 01 4000 A5A5 01 3",
               k1, a1, wd1, be1, stl);
    end
    n_checks++;
    if (mdr_d !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL stb_mdr_hold: got %h required BEEF", mdr_d);
    end
  endtask

  task automatic test_ldb;
    run_access(1'b1, 1'b0, 1'b0, 1'b1, 16'h5001, 16'h0000, 16'h8034, 16'h0000, 0, 0, 0);
    n_checks++;
    if ({mdr_d, a1} !== {16'hFF80, 16'h5000}) begin
      n_fails++;
      $display("FAIL ldb_high: got mdr=%h addr=%h required FF80 5000", mdr_d, a1);
    end
    run_access(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000, 16'h0000, 16'h8034, 16'h0000, 0, 0, 0);
    n_checks++;
    if (mdr_d !== 16'h0034) begin
      n_fails++;
      $display("FAIL ldb_low: got %h required 0034", mdr_d);
    end
  endtask

  task automatic test_ldi;
    run_access(1'b1, 1'b0, 1'b1, 1'b0, 16'h6000, 16'h0000, 16'h7002, 16'h1234, 3, 3, 0);
    n_checks++;
    if ({a1, k1, a2, k2} !== {16'h6000, 2'b10, 16'h7002, 2'b10}) begin
      n_fails++;
      $display("FAIL ldi_addr: got a1=%h k1=%b a2=%h k2=%b required 6000 10 7002 10", a1, k1, a2, k2);
    end
    n_checks++;
    if ({mdr_d, 16'(cyc), 16'(stl)} !== {16'h1234, 16'd10, 16'd9}) begin
      n_fails++;
      $display("FAIL ldi_result: got mdr=%h cyc=%0d stall=%0d required 1234 10 9", mdr_d, cyc, stl);
    end
  endtask

  task automatic test_sti_hold;
    run_access(1'b0, 1'b1, 1'b1, 1'b0, 16'h6101, 16'hCAFE, 16'h7101, 16'h0000, 0, 0, 3);
    n_checks++;
    if ({k1, a1, k2, a2, wd2, be2} !== {2'b10, 16'h6100, 2'b01, 16'h7100, 16'hCAFE, 2'b11}) begin
      n_fails++;
      $display("FAIL sti_access: got k1=%b a1=%h k2=%b a2=%h wd=%h be=%b required 10 6100 01 7100 CAFE 11",
               k1, a1, k2, a2, wd2, be2);
    end
    n_checks++;
    if ({16'(cyc), 16'(stl), 16'(dreq), mdr_d} !== {16'd7, 16'd3, 16'd0, 16'h1234}) begin
      n_fails++;
      $display("FAIL sti_done_hold: got cyc=%0d stall=%0d done_req=%0d mdr=%h required 7 3 0 1234",
               cyc, stl, dreq, mdr_d);
    end
    #1;
    n_checks++;
    if ({stall_mem, dmem_read, dmem_write} !== 3'b000) begin
      n_fails++;
      $display("FAIL sti_back_idle: got stall=%b rd=%b wr=%b required 000", stall_mem, dmem_read, dmem_write);
    end
  endtask

  task automatic test_passthrough;
    int bad;
    bad = 0;
    @(negedge clk);
    valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr_in = 16'h1111;
    dmem_resp = 1'b1; dmem_rdata = 16'h5A5A;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 3) begin
        valid_in = 1'b0; mem_read = 1'b1; mem_write = 1'b1; indirect = 1'b1;
        #1;
      end
      if (stall_mem || dmem_read || dmem_write) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++;
      $display("FAIL passthrough: got %0d stall/request cycles required 0", bad);
    end
    n_checks++;
    if (mdr_out !== 16'h1234) begin
      n_fails++;
      $display("FAIL stray_resp_mdr: got %h required 1234", mdr_out);
    end
    mem_read = 1'b0; mem_write = 1'b0; indirect = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic test_back_to_back;
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000, 16'h0101, 16'h0000, 0, 0, 0);
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h3003, 16'h0000, 16'h0202, 16'h0000, 0, 0, 0);
    n_checks++;
    if ({a1, mdr_d, 16'(cyc), 16'(stl)} !== {16'h3002, 16'h0202, 16'd3, 16'd2}) begin
      n_fails++;
      $display("FAIL back_to_back: got addr=%h mdr=%h cyc=%0d stall=%0d required 3002 0202 3 2",
               a1, mdr_d, cyc, stl);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    valid_in = 1'b1; mem_write = 1'b1; indirect = 1'b1; addr_in = 16'h6200; store_data = 16'h5555;
    @(negedge clk);
    valid_in = 1'b0; mem_write = 1'b0; indirect = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 16'h7200;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    n_checks++;
    if ({dmem_write, dmem_addr} !== {1'b1, 16'h7200}) begin
      n_fails++;
      $display("FAIL sti_acc2: got wr=%b addr=%h required 1 7200", dmem_write, dmem_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dmem_read, dmem_write, dmem_byte_en, stall_mem, dmem_addr, mdr_out} !== 37'h0) begin
      n_fails++;
      $display("FAIL async_reset: got rd=%b wr=%b be=%b stall=%b addr=%h mdr=%h required all 0",
               dmem_read, dmem_write, dmem_byte_en, stall_mem, dmem_addr, mdr_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h3004, 16'h0000, 16'h0F0F, 16'h0000, 0, 0, 0);
    n_checks++;
    if ({a1, mdr_d, 16'(cyc), 16'(stl)} !== {16'h3004, 16'h0F0F, 16'd3, 16'd2}) begin
      n_fails++;
      $display("FAIL ldr_after_reset: got addr=%h mdr=%h cyc=%0d stall=%0d required 3004 0F0F 3 2",
               a1, mdr_d, cyc, stl);
    end
  endtask

  initial begin
    test_reset;
    test_ldr;
    test_stb;
    test_ldb;
    test_ldi;
    test_sti_hold;
    test_passthrough;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
